rv32i_decode_stage: RTL and testbench

Registered instruction-decode stage that sits between instruction fetch and the ALU. It accepts one 32-bit RV32I instruction per valid/ready handshake and breaks it into fields and control signals. It produces exactly the operand-select and field inputs the ALU consumes: opcode, funct3, funct7, ALU_source and immediate, plus register indices and memory/writeback controls. It has one output register stage with backpressure and a synchronous flush for taken branches and jumps.

---
 rtl/rv32i_decode_stage.sv | 263 ++++++++++++++++++++++++++
 tb/tb_rv32i_decode_stage.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_decode_stage
// Purpose  : Registered RV32I instruction decode stage. Splits one instruction
//            per valid/ready handshake into the fields and control signals the
//            ALU and later stages consume. It has one output register with
//            backpressure and a synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_decode_stage (
  input  logic        clk,
  input  logic        nRst,
  input  logic        instr_valid,
  input  logic [31:0] instruction,
  output logic        instr_ready,
  input  logic        flush,
  input  logic        out_ready,
  output logic        dec_valid,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rs1_sel,
  output logic [4:0]  rs2_sel,
  output logic [4:0]  rd_sel,
  output logic [31:0] immediate,
  output logic        ALU_source,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        is_branch,
  output logic        is_jump,
  output logic        illegal
);

  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] c_F7_BASE   = 7'b0000000;
  localparam logic [6:0] c_F7_ALT    = 7'b0100000;

  localparam logic [2:0] c_F3_ADDSUB = 3'b000;
  localparam logic [2:0] c_F3_SLL    = 3'b001;
  localparam logic [2:0] c_F3_SR     = 3'b101;

  // Field aliases of the incoming word
  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic [6:0] w_f7_raw;
  logic       w_accept;

  assign w_op     = instruction[6:0];
  assign w_f3     = instruction[14:12];
  assign w_f7_raw = instruction[31:25];

  // Decoded values of the instruction currently offered by fetch
  logic        w_is_shift;
  logic        w_known_op;
  logic [6:0]  w_f7;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic [31:0] w_imm;
  logic        w_alu_src;
  logic        w_reg_write;
  logic        w_mem_read;
  logic        w_mem_write;
  logic        w_branch;
  logic        w_jump;
  logic        w_illegal;

  // Registered decode payload
  logic        r_valid;
  logic [6:0]  r_opcode;
  logic [2:0]  r_funct3;
  logic [6:0]  r_funct7;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [4:0]  r_rd;
  logic [31:0] r_imm;
  logic        r_alu_src;
  logic        r_reg_write;
  logic        r_mem_read;
  logic        r_mem_write;
  logic        r_branch;
  logic        r_jump;
  logic        r_illegal;

  assign w_is_shift = (w_op == c_OP_IMM) && ((w_f3 == c_F3_SLL) || (w_f3 == c_F3_SR));

  // Handshake: a flush blocks acceptance, and a full register only frees up when consumed
  assign instr_ready = !flush && (!r_valid || out_ready);
  assign w_accept    = instr_valid && instr_ready;

  // Format-dependent field, immediate and raw control decode
  always_comb begin
    w_known_op  = 1'b1;
    w_f7        = 7'd0;
    w_rs1       = instruction[19:15];
    w_rs2       = 5'd0;
    w_rd        = instruction[11:7];
    w_imm       = 32'd0;
    w_alu_src   = 1'b0;
    w_reg_write = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_branch    = 1'b0;
    w_jump      = 1'b0;
    case (w_op)
      c_OP_R: begin
        w_f7        = w_f7_raw;
        w_rs2       = instruction[24:20];
        w_reg_write = 1'b1;
      end
      c_OP_IMM: begin
        // funct7 is only meaningful for shifts; elsewhere those bits are immediate
        if (w_is_shift) begin
          w_f7  = w_f7_raw;
          w_imm = {27'd0, instruction[24:20]};
        end else begin
          w_imm = {{20{instruction[31]}}, instruction[31:20]};
        end
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
      end
      c_OP_LOAD: begin
        w_imm       = {{20{instruction[31]}}, instruction[31:20]};
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
        w_mem_read  = 1'b1;
      end
      c_OP_JALR: begin
        w_imm       = {{20{instruction[31]}}, instruction[31:20]};
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
        w_jump      = 1'b1;
      end
      c_OP_STORE: begin
        w_rs2       = instruction[24:20];
        w_rd        = 5'd0;
        w_imm       = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      c_OP_BRANCH: begin
        w_rs2    = instruction[24:20];
        w_rd     = 5'd0;
        w_imm    = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
        w_branch = 1'b1;
      end
      c_OP_LUI, c_OP_AUIPC: begin
        w_rs1       = 5'd0;
        w_imm       = {instruction[31:12], 12'd0};
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
      end
      c_OP_JAL: begin
        w_rs1       = 5'd0;
        w_imm       = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                       instruction[20], instruction[30:21], 1'b0};
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
        w_jump      = 1'b1;
      end
      default: begin
        // Unknown opcode: report zeroed fields so nothing downstream sees junk
        w_known_op = 1'b0;
        w_rs1      = 5'd0;
        w_rd       = 5'd0;
      end
    endcase
  end

  // Unsupported-encoding detection
  always_comb begin
    w_illegal = !w_known_op;
    if (w_op == c_OP_R) begin
      if ((w_f7_raw != c_F7_BASE) && (w_f7_raw != c_F7_ALT)) begin
        w_illegal = 1'b1;
      end else if ((w_f7_raw == c_F7_ALT) && (w_f3 != c_F3_ADDSUB) && (w_f3 != c_F3_SR)) begin
        w_illegal = 1'b1;
      end
    end else if (w_is_shift) begin
      // Only SRAI may carry the alternate funct7
      if (!((w_f7_raw == c_F7_BASE) || ((w_f7_raw == c_F7_ALT) && (w_f3 == c_F3_SR)))) begin
        w_illegal = 1'b1;
      end
    end
  end

  // Output-valid tracking: flush wins, then accept, then consume
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_valid <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Payload capture on accept; an illegal encoding suppresses all side effects
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_opcode    <= 7'd0;
      r_funct3    <= 3'd0;
      r_funct7    <= 7'd0;
      r_rs1       <= 5'd0;
      r_rs2       <= 5'd0;
      r_rd        <= 5'd0;
      r_imm       <= 32'd0;
      r_alu_src   <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_branch    <= 1'b0;
      r_jump      <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_accept) begin
      r_opcode    <= w_op;
      r_funct3    <= w_f3;
      r_funct7    <= w_f7;
      r_rs1       <= w_rs1;
      r_rs2       <= w_rs2;
      r_rd        <= w_rd;
      r_imm       <= w_imm;
      r_alu_src   <= w_alu_src;
      r_reg_write <= w_reg_write && !w_illegal;
      r_mem_read  <= w_mem_read  && !w_illegal;
      r_mem_write <= w_mem_write && !w_illegal;
      r_branch    <= w_branch    && !w_illegal;
      r_jump      <= w_jump      && !w_illegal;
      r_illegal   <= w_illegal;
    end
  end

  assign dec_valid  = r_valid;
  assign opcode     = r_opcode;
  assign funct3     = r_funct3;
  assign funct7     = r_funct7;
  assign rs1_sel    = r_rs1;
  assign rs2_sel    = r_rs2;
  assign rd_sel     = r_rd;
  assign immediate  = r_imm;
  assign ALU_source = r_alu_src;
  assign reg_write  = r_reg_write;
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign is_branch  = r_branch;
  assign is_jump    = r_jump;
  assign illegal    = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_decode_stage
// Purpose  : Self-checking bench for rv32i_decode_stage: directed vector
//            table, handshake corner sequences and randomized traffic against
//            a behavioural decode model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_decode_stage;

  logic        clk = 1'b0;
  logic        nRst;
  logic        instr_valid;
  logic [31:0] instruction;
  logic        instr_ready;
  logic        flush;
  logic        out_ready;
  logic        dec_valid;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1_sel;
  logic [4:0]  rs2_sel;
  logic [4:0]  rd_sel;
  logic [31:0] immediate;
  logic        ALU_source;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        is_branch;
  logic        is_jump;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        alu_src;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        jmp;
    logic        ill;
  } dec_t;

  typedef struct {
    logic [31:0] instr;
    dec_t        exp;
  } vec_t;

  localparam logic [31:0] c_ADD  = 32'h002081B3;
  localparam logic [31:0] c_SUB  = 32'h402081B3;
  localparam logic [31:0] c_ADDI = 32'hFFF00093;

  rv32i_decode_stage dut (
    .clk         (clk),
    .nRst        (nRst),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .instr_ready (instr_ready),
    .flush       (flush),
    .out_ready   (out_ready),
    .dec_valid   (dec_valid),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .rs1_sel     (rs1_sel),
    .rs2_sel     (rs2_sel),
    .rd_sel      (rd_sel),
    .immediate   (immediate),
    .ALU_source  (ALU_source),
    .reg_write   (reg_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .is_branch   (is_branch),
    .is_jump     (is_jump),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_dec(input string name, input dec_t e);
    chk({name, ".opcode"},  32'(opcode),     32'(e.opcode));
    chk({name, ".funct3"},  32'(funct3),     32'(e.funct3));
    chk({name, ".funct7"},  32'(funct7),     32'(e.funct7));
    chk({name, ".rs1"},     32'(rs1_sel),    32'(e.rs1));
    chk({name, ".rs2"},     32'(rs2_sel),    32'(e.rs2));
    chk({name, ".rd"},      32'(rd_sel),     32'(e.rd));
    chk({name, ".imm"},     immediate,       e.imm);
    chk({name, ".alu_src"}, 32'(ALU_source), 32'(e.alu_src));
    chk({name, ".ctrl"},
        32'({reg_write, mem_read, mem_write, is_branch, is_jump, illegal}),
        32'({e.rw, e.mr, e.mw, e.br, e.jmp, e.ill}));
  endtask

  // Sign-extend the low 'bits' bits of v using plain arithmetic
  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    logic [31:0] m;
    m = 32'd1 << (bits - 1);
    return (v ^ m) - m;
  endfunction

  // Behavioural decode model written from the ISA field rules
  function automatic dec_t model(input logic [31:0] i);
    dec_t d;
    logic [6:0] f7;
    logic [2:0] f3;
    d = '0;
    f7 = 7'((i >> 25) & 32'h7F);
    f3 = 3'((i >> 12) & 32'h7);
    d.opcode = 7'(i & 32'h7F);
    d.funct3 = f3;
    case (d.opcode)
      7'h33: begin
        d.funct7 = f7; d.rs1 = 5'(i >> 15); d.rs2 = 5'(i >> 20); d.rd = 5'(i >> 7);
        d.rw = 1;
        d.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      7'h13: begin
        d.rs1 = 5'(i >> 15); d.rd = 5'(i >> 7); d.alu_src = 1; d.rw = 1;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          d.funct7 = f7;
          d.imm = (i >> 20) & 32'h1F;
          d.ill = !(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd5));
        end else begin
          d.imm = sext(i >> 20, 12);
        end
      end
      7'h03: begin
        d.rs1 = 5'(i >> 15); d.rd = 5'(i >> 7); d.imm = sext(i >> 20, 12);
        d.alu_src = 1; d.rw = 1; d.mr = 1;
      end
      7'h67: begin
        d.rs1 = 5'(i >> 15); d.rd = 5'(i >> 7); d.imm = sext(i >> 20, 12);
        d.alu_src = 1; d.rw = 1; d.jmp = 1;
      end
      7'h23: begin
        d.rs1 = 5'(i >> 15); d.rs2 = 5'(i >> 20);
        d.imm = sext(((i >> 25) << 5) | ((i >> 7) & 32'h1F), 12);
        d.alu_src = 1; d.mw = 1;
      end
      7'h63: begin
        d.rs1 = 5'(i >> 15); d.rs2 = 5'(i >> 20);
        d.imm = sext((((i >> 31) & 1) << 12) | (((i >> 7) & 1) << 11) |
                     (((i >> 25) & 32'h3F) << 5) | (((i >> 8) & 32'hF) << 1), 13);
        d.br = 1;
      end
      7'h37, 7'h17: begin
        d.rd = 5'(i >> 7); d.imm = i & 32'hFFFFF000; d.alu_src = 1; d.rw = 1;
      end
      7'h6F: begin
        d.rd = 5'(i >> 7);
        d.imm = sext((((i >> 31) & 1) << 20) | (((i >> 12) & 32'hFF) << 12) |
                     (((i >> 20) & 1) << 11) | (((i >> 21) & 32'h3FF) << 1), 21);
        d.alu_src = 1; d.rw = 1; d.jmp = 1;
      end
      default: d.ill = 1;
    endcase
    if (d.ill) begin
      d.rw = 0; d.mr = 0; d.mw = 0; d.br = 0; d.jmp = 0;
    end
    return d;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10];
    logic [31:0] w;
    int k;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h13};
    w = $urandom;
    if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 9)];
    if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
      k = $urandom_range(0, 3);
      if (k == 0) w[31:25] = 7'h00;
      else if (k == 1) w[31:25] = 7'h20;
    end
    return w;
  endfunction

  vec_t vecs [10];
  dec_t zero_d;
  dec_t exp_d;
  logic exp_valid;
  logic exp_ready;

  initial begin
    // opcode, f3, f7, rs1, rs2, rd, imm, src, rw, mr, mw, br, jmp, ill
    vecs[0] = '{c_ADD,  '{7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[1] = '{c_SUB,  '{7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[2] = '{c_ADDI, '{7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[3] = '{32'h4030D093, '{7'h13, 3'd5, 7'h20, 5'd1, 5'd0, 5'd1, 32'h3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[4] = '{32'hFE208EE3, '{7'h63, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[5] = '{32'h0000007F, '{7'h7F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}};
    vecs[6] = '{32'h123452B7, '{7'h37, 3'd5, 7'h00, 5'd0, 5'd0, 5'd5, 32'h12345000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[7] = '{32'h0020A423, '{7'h23, 3'd2, 7'h00, 5'd1, 5'd2, 5'd0, 32'h8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[8] = '{32'h40109093, '{7'h13, 3'd1, 7'h20, 5'd1, 5'd0, 5'd1, 32'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}};
    vecs[9] = '{32'h402091B3, '{7'h33, 3'd1, 7'h20, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}};
    zero_d = '0;

    // Reset state
    nRst = 1'b0; instr_valid = 1'b0; instruction = 32'd0; flush = 1'b0; out_ready = 1'b0;
    #2;
    chk("reset.dec_valid", 32'(dec_valid), 32'd0);
    chk("reset.instr_ready", 32'(instr_ready), 32'd1);
    chk_dec("reset", zero_d);
    @(negedge clk);
    nRst = 1'b1;

    // Directed vector table, one instruction per cycle with downstream always ready
    for (int v = 0; v < 10; v++) begin
      instruction = vecs[v].instr; instr_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d.dec_valid", v), 32'(dec_valid), 32'd1);
      chk_dec($sformatf("vec%0d", v), vecs[v].exp);
    end
    instr_valid = 1'b0;
    @(negedge clk);
    chk("drain.dec_valid", 32'(dec_valid), 32'd0);

    // Backpressure: ADD held for 3 cycles while SUB is offered, then no-bubble swap
    instruction = c_ADD; instr_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    instruction = c_SUB; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp.instr_ready", 32'(instr_ready), 32'd0);
      chk("bp.dec_valid", 32'(dec_valid), 32'd1);
      chk_dec("bp.hold", vecs[0].exp);
      @(negedge clk);
    end
    chk_dec("bp.after", vecs[0].exp);
    out_ready = 1'b1;
    #1;
    chk("bp.release_ready", 32'(instr_ready), 32'd1);
    @(negedge clk);
    chk("bp.swap_valid", 32'(dec_valid), 32'd1);
    chk_dec("bp.swap", vecs[1].exp);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("consume.dec_valid", 32'(dec_valid), 32'd0);

    // Flush with a held entry and a new instruction offered
    instruction = c_ADD; instr_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b1; instruction = c_SUB; out_ready = 1'b0;
    #1;
    chk("flush.instr_ready", 32'(instr_ready), 32'd0);
    @(negedge clk);
    chk("flush.dec_valid", 32'(dec_valid), 32'd0);
    flush = 1'b0; instr_valid = 1'b0;

    // Asynchronous reset in the middle of a hold
    instruction = c_ADDI; instr_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("prereset.dec_valid", 32'(dec_valid), 32'd1);
    #2;
    nRst = 1'b0;
    #1;
    chk("async_reset.dec_valid", 32'(dec_valid), 32'd0);
    chk("async_reset.instr_ready", 32'(instr_ready), 32'd1);
    chk_dec("async_reset", zero_d);
    @(negedge clk);
    nRst = 1'b1;

    // Randomized traffic against the model
    exp_valid = 1'b0;
    exp_d = '0;
    for (int n = 0; n < 400; n++) begin
      chk("rnd.dec_valid", 32'(dec_valid), 32'(exp_valid));
      if (exp_valid) chk_dec("rnd", exp_d);
      flush       = ($urandom_range(0, 15) == 0);
      instr_valid = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      instruction = rand_instr();
      exp_ready   = !flush && (!exp_valid || out_ready);
      #1;
      chk("rnd.instr_ready", 32'(instr_ready), 32'(exp_ready));
      if (flush) begin
        exp_valid = 1'b0;
      end else if (instr_valid && exp_ready) begin
        exp_valid = 1'b1;
        exp_d = model(instruction);
      end else if (out_ready) begin
        exp_valid = 1'b0;
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
